// File: rtl/uart_pkg.sv
// Shared UART framing definitions.
// Used by both ends of the serial link.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  function automatic int unsigned clks_per_bit(
    input int unsigned clk_freq,
    input int unsigned baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first.
// Mid-bit sampling of a synchronised line.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CLKS_PER_BIT =
    clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [31:0] BIT_END  = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] HALF_END = 32'(HALF_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic        fall;

  uart_state_t state;
  uart_state_t state_next;
  logic [31:0] clk_count;
  logic [31:0] clk_count_next;
  logic [2:0]  bit_index;
  logic [2:0]  bit_index_next;
  logic [7:0]  data_shift;
  logic [7:0]  shift_next;
  logic [7:0]  data_next;
  logic        valid_next;
  logic        ferr_next;

  // Two-flop synchroniser plus one history flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall    = rx_prev & ~rx_sync;
  assign rx_busy = (state != IDLE);

  // Frame state, counters and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      clk_count    <= '0;
      bit_index    <= '0;
      data_shift   <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      state        <= state_next;
      clk_count    <= clk_count_next;
      bit_index    <= bit_index_next;
      data_shift   <= shift_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_frame_err <= ferr_next;
    end
  end

  // Next-state, bit-centre sampling and pulse generation
  always_comb begin
    state_next     = state;
    clk_count_next = clk_count + 32'd1;
    bit_index_next = bit_index;
    shift_next     = data_shift;
    data_next      = rx_data;
    valid_next     = 1'b0;
    ferr_next      = 1'b0;
    unique case (state)
      IDLE: begin
        clk_count_next = '0;
        bit_index_next = '0;
        if (fall) state_next = START;
      end
      START: begin
        if (clk_count == HALF_END) begin
          clk_count_next = '0;
          state_next     = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_count == BIT_END) begin
          clk_count_next        = '0;
          shift_next[bit_index] = rx_sync;
          if (bit_index == 3'd7) begin
            state_next     = STOP;
            bit_index_next = '0;
          end else begin
            bit_index_next = bit_index + 3'd1;
          end
        end
      end
      STOP: begin
        if (clk_count == BIT_END) begin
          clk_count_next = '0;
          state_next     = IDLE;
          if (rx_sync) begin
            data_next  = data_shift;
            valid_next = 1'b1;
          end else begin
            ferr_next  = 1'b1;
          end
        end
      end
      default: begin
        clk_count_next = '0;
        state_next     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// 1 MHz clock model, 100 kbaud, 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int start_cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int ferr_cnt = 0;
  int busy_cyc = 0;
  int busy_rise = 0;
  int overlap = 0;
  logic busy_q = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] got_q[$];

  uart_rx #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs away from the active edge
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      last_data = rx_data;
      got_q.push_back(rx_data);
    end
    if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && rx_frame_err) overlap = overlap + 1;
    if (rx_busy) busy_cyc = busy_cyc + 1;
    if (rx_busy && !busy_q) busy_rise = busy_rise + 1;
    busy_q = rx_busy;
  end

  // Drive one frame; the line is left at the stop level
  task automatic send_frame(
    input logic [7:0] d,
    input logic       stop,
    input int         bit_ns
  );
    @(negedge clk);
    start_cyc = cyc;
    rx_serial = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      #(bit_ns);
    end
    rx_serial = stop;
    #(bit_ns);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", rx_data);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", rx_valid);
    end
    checks++;
    if (rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ferr got=%b exp=0", rx_frame_err);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", rx_busy);
    end
  endtask

  task automatic test_basic();
    int v0;
    int f0;
    int lat;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 100);
    repeat (20) @(negedge clk);
    lat = valid_cyc - start_cyc;
    checks++;
    if (valid_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL basic_pulses got=%0d exp=1", valid_cnt - v0);
    end
    checks++;
    if (last_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_data got=%h exp=a5", last_data);
    end
    checks++;
    if (lat < 97 || lat > 99) begin
      failures++;
      $display("FAIL basic_latency got=%0d exp=98+-1", lat);
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      failures++;
      $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    int base;
    int v0;
    int f0;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h55;
    exp_b[3] = 8'h80;
    base = got_q.size();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, 100);
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 4) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=4", valid_cnt - v0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() <= base + i) begin
        failures++;
        $display("FAIL b2b_data%0d got=none exp=%h", i, exp_b[i]);
      end else if (got_q[base + i] !== exp_b[i]) begin
        failures++;
        $display("FAIL b2b_data%0d got=%h exp=%h",
                 i, got_q[base + i], exp_b[i]);
      end
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      failures++;
      $display("FAIL b2b_ferr got=%0d exp=0", ferr_cnt - f0);
    end
  endtask

  task automatic test_glitch();
    int v0;
    int f0;
    int b0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    b0 = busy_cyc;
    @(negedge clk);
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (150) @(negedge clk);
    checks++;
    if (busy_cyc - b0 !== 5) begin
      failures++;
      $display("FAIL glitch_busy_len got=%0d exp=5", busy_cyc - b0);
    end
    checks++;
    if (valid_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0);
    end
    checks++;
    if (ferr_cnt - f0 !== 0) begin
      failures++;
      $display("FAIL glitch_ferr got=%0d exp=0", ferr_cnt - f0);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_idle got=%b exp=0", rx_busy);
    end
  endtask

  task automatic test_frame_err();
    int v0;
    int f0;
    int r0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    r0 = busy_rise;
    send_frame(8'h3C, 1'b0, 100);
    repeat (30) @(negedge clk);
    rx_serial = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      failures++;
      $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0);
    end
    checks++;
    if (valid_cnt - v0 !== 0) begin
      failures++;
      $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0);
    end
    checks++;
    if (rx_data !== 8'h80) begin
      failures++;
      $display("FAIL ferr_data_held got=%h exp=80", rx_data);
    end
    checks++;
    if (busy_rise - r0 !== 1) begin
      failures++;
      $display("FAIL ferr_break_retrigger got=%0d exp=1",
               busy_rise - r0);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    int f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    fork
      send_frame(8'h96, 1'b1, 100);
      begin
        @(negedge clk);
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rx_busy !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_busy got=%b exp=0", rx_busy);
        end
        checks++;
        if (rx_data !== 8'h00) begin
          failures++;
          $display("FAIL rstmid_data got=%h exp=00", rx_data);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_valid got=%b exp=0", rx_valid);
        end
        checks++;
        if (rx_frame_err !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_ferr got=%b exp=0", rx_frame_err);
        end
        repeat (48) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    checks++;
    if (valid_cnt - v0 + ferr_cnt - f0 !== 0) begin
      failures++;
      $display("FAIL rstmid_no_pulse got=%0d exp=0",
               valid_cnt - v0 + ferr_cnt - f0);
    end
    send_frame(8'h42, 1'b1, 100);
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL rstmid_next_pulses got=%0d exp=1",
               valid_cnt - v0);
    end
    checks++;
    if (last_data !== 8'h42) begin
      failures++;
      $display("FAIL rstmid_next_data got=%h exp=42", last_data);
    end
  endtask

  task automatic test_baud_skew();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1, 104);
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL skew_pulses got=%0d exp=1", valid_cnt - v0);
    end
    checks++;
    if (last_data !== 8'hC3) begin
      failures++;
      $display("FAIL skew_data got=%h exp=c3", last_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_baud_skew();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL valid_ferr_overlap got=%0d exp=0", overlap);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
